ham_enc_stream_14_10: RTL and testbench

Streaming Hamming(14,10) SEC encoder, the transmit-side counterpart of the 14/10 SEC decoder in the Dynamic-TMR demo controller. It accepts 10-bit data words over a valid/ready handshake and computes the four parity bits. It places data and parity in the codeword bit layout the decoder expects, and buffers codewords in a 2-entry output FIFO. A test hook flips one selected codeword bit, so the decoder's correction path can be exercised on demand.

---
 rtl/ham_14_10_pkg.sv | 48 ++++
 rtl/ham_enc_stream_14_10_if.sv | 40 ++++
 rtl/ham_enc_14_10_core.sv | 28 ++
 rtl/ham_enc_stream_14_10.sv | 123 ++++++++++++
 tb/tb_ham_enc_stream_14_10.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ham_14_10_pkg.sv
// ----------------------------------------------------------------------------
// ham_14_10_pkg
//
// Shared definitions for the Hamming(14,10) SEC encoder and decoder.
// Provides:
//   - DATA_W, CODE_W and PAR_W width constants.
//   - data_t and code_t word types.
//   - PARITY_POS: the codeword bit indices that hold parity.
//   - DATA_POS: maps data bit i to its codeword bit index.
//   - parity_mask(): the set of data bits covered by each parity bit.
//   - pos_valid(): checks a 1-based codeword position.
//
// Codeword bit k sits at Hamming position k+1. Parity bits therefore land on
// the power-of-two positions 1, 2, 4 and 8. Parity bit j covers every data
// bit whose Hamming position has bit j set.
// ----------------------------------------------------------------------------
package ham_14_10_pkg;

    localparam int DATA_W = 10;
    localparam int CODE_W = 14;
    localparam int PAR_W  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] code_t;

    localparam int PARITY_POS [PAR_W] = '{0, 1, 3, 7};

    localparam int DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13};

    // Data bits that feed parity bit k, derived from the position map.
    // The encoder then cannot drift out of step with the decoder's syndrome.
    function automatic data_t parity_mask(input int k);
        data_t mask;
        mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if ((((DATA_POS[i] + 1) >> k) & 1) != 0) begin
                mask = mask | (data_t'(1) << i);
            end
        end
        return mask;
    endfunction

    // Only positions 1..CODE_W name a real codeword bit.
    function automatic logic pos_valid(input logic [3:0] pos);
        return (pos != 4'd0) && (pos <= 4'(CODE_W));
    endfunction

endpackage

// File: rtl/ham_enc_stream_14_10_if.sv
// ----------------------------------------------------------------------------
// ham_enc_stream_14_10_if
//
// Streaming handshake bundle for the Hamming(14,10) encoder.
//   in_valid  / in_ready  / in_data  : 10-bit data words into the encoder
//   out_valid / out_ready / out_code : 14-bit codewords out of the encoder
//
// Modports:
//   slave  : the encoder's view (consumes in_*, produces out_*)
//   master : the producer/consumer environment around the encoder
// ----------------------------------------------------------------------------
interface ham_enc_stream_14_10_if;
    import ham_14_10_pkg::*;

    logic  in_valid;
    logic  in_ready;
    data_t in_data;
    logic  out_valid;
    logic  out_ready;
    code_t out_code;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_code
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_code
    );

endinterface

// File: rtl/ham_enc_14_10_core.sv
// ----------------------------------------------------------------------------
// ham_enc_14_10_core
//
// Purely combinational Hamming(14,10) encode of one data word.
// Ports:
//   data  in  10  data word d[9:0]
//   code  out 14  unflipped codeword c[13:0]
//
// Data bits are scattered to their codeword slots through DATA_POS. Each
// parity slot is the XOR of the data bits that its mask selects.
// ----------------------------------------------------------------------------
module ham_enc_14_10_core
    import ham_14_10_pkg::*;
(
    input  data_t data,
    output code_t code
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        assign code[DATA_POS[i]] = data[i];
    end

    for (genvar k = 0; k < PAR_W; k++) begin : g_parity
        localparam data_t MASK = parity_mask(k);
        assign code[PARITY_POS[k]] = ^(data & MASK);
    end

endmodule

// File: rtl/ham_enc_stream_14_10.sv
// ----------------------------------------------------------------------------
// ham_enc_stream_14_10
//
// Streaming Hamming(14,10) SEC encoder with a 2-entry output FIFO and a
// single-bit error-injection hook for exercising the decoder's correction.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   en         in   1   block enable; low blocks new input, FIFO still drains
//   strm       if       stream handshake (slave modport): in_* / out_*
//   inj_req    in   1   arm error injection, latches inj_pos
//   inj_pos    in   4   1-based codeword position to flip (1..14)
//   inj_ack    out  1   one-cycle pulse when the armed injection was applied
//   enc_count  out  16  number of words accepted, wraps
// ----------------------------------------------------------------------------
module ham_enc_stream_14_10
    import ham_14_10_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    ham_enc_stream_14_10_if.slave  strm,
    input  logic                   inj_req,
    input  logic [3:0]             inj_pos,
    output logic                   inj_ack,
    output logic [15:0]            enc_count
);

    code_t       enc_code;
    code_t       flip_mask;
    code_t       store_code;
    code_t       fifo_mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  fifo_cnt;
    logic        armed;
    logic [3:0]  arm_pos;
    logic        accept;
    logic        pop;

    ham_enc_14_10_core u_core (
        .data (strm.in_data),
        .code (enc_code)
    );

    // in_ready depends only on registered state, en and rst. It never looks
    // at out_ready, so no combinational path runs from the consumer back to
    // the producer.
    assign strm.in_ready  = !rst && en && (fifo_cnt != 2'd2);
    assign strm.out_valid = (fifo_cnt != 2'd0);
    assign strm.out_code  = fifo_mem[rd_ptr];

    assign accept = strm.in_valid && strm.in_ready;
    assign pop    = strm.out_valid && strm.out_ready;

    // The flip mask comes from the armed state before this edge. A request
    // arriving with an accept therefore affects the following word only.
    // Out-of-range positions give an empty mask, but they still consume the
    // arm.
    always_comb begin
        flip_mask = '0;
        if (armed && pos_valid(arm_pos)) begin
            flip_mask = code_t'(1) << (arm_pos - 4'd1);
        end
    end

    assign store_code = enc_code ^ flip_mask;

    // Two-entry FIFO built from 1-bit pointers and an occupancy count.
    // The storage is reset as well, so out_code reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr] <= store_code;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Injection arm. A new request always wins and overwrites the position.
    // Otherwise an accept consumes the arm. inj_ack is registered, so it
    // rises together with the affected word's entry into the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed   <= 1'b0;
            arm_pos <= 4'd0;
            inj_ack <= 1'b0;
        end else begin
            inj_ack <= accept && armed;
            if (inj_req) begin
                armed   <= 1'b1;
                arm_pos <= inj_pos;
            end else if (accept) begin
                armed <= 1'b0;
            end
        end
    end

    // Count of accepted words. It wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count <= 16'd0;
        end else if (accept) begin
            enc_count <= enc_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ham_enc_stream_14_10.sv
// ----------------------------------------------------------------------------
// tb_ham_enc_stream_14_10
//
// Self-checking bench for ham_enc_stream_14_10. A behavioural model tracks
// the expected FIFO contents, counter and injection state. The model is
// compared against the DUT on every falling edge. A bench-side syndrome
// decoder checks that every codeword leaving the DUT decodes to its data.
// ----------------------------------------------------------------------------
module tb_ham_enc_stream_14_10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        inj_req = 1'b0;
    logic [3:0]  inj_pos = 4'd0;
    logic        inj_ack;
    logic [15:0] enc_count;

    int checks = 0;
    int errors = 0;

    ham_enc_stream_14_10_if bus ();

    ham_enc_stream_14_10 dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .strm      (bus),
        .inj_req   (inj_req),
        .inj_pos   (inj_pos),
        .inj_ack   (inj_ack),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] code;
        logic [9:0]  data;
        bit          flipped;
    } exp_t;

    exp_t        exp_q [$];
    bit          m_armed = 1'b0;
    logic [3:0]  m_pos = 4'd0;
    bit          m_ack = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    int          data_pos [10] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13};

    // Monitor scratch variables
    exp_t        mon_e;
    logic [9:0]  mon_d;
    bit          mon_err;
    bit          mon_acc;
    bit          mon_pop;
    int          mon_idx;

    // Direct parity equations and bit layout of the code
    function automatic logic [13:0] encode(input logic [9:0] d);
        logic [13:0] c;
        c     = '0;
        c[2]  = d[0];  c[4]  = d[1];  c[5]  = d[2];  c[6]  = d[3];
        c[8]  = d[4];  c[9]  = d[5];  c[10] = d[6];  c[11] = d[7];
        c[12] = d[8];  c[13] = d[9];
        c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8];
        c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9];
        c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9];
        c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9];
        return c;
    endfunction

    // Syndrome decode: the XOR of the 1-based positions of all set bits
    function automatic void decode(input logic [13:0] c_in, output logic [9:0] d, output bit err);
        logic [13:0] c;
        int s;
        c = c_in;
        s = 0;
        for (int i = 0; i < 14; i++) begin
            if (c[i]) s = s ^ (i + 1);
        end
        err = (s != 0);
        if (s >= 1 && s <= 14) c[s-1] = ~c[s-1];
        for (int i = 0; i < 10; i++) d[i] = c[data_pos[i]];
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one word and holds in_valid until the edge that accepts it.
    task automatic apply_stimulus(input logic [9:0] d);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready 0 expected 1 for data %0h", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_inj(input logic [3:0] p);
        inj_req = 1'b1;
        inj_pos = p;
        @(posedge clk);
        #1;
        inj_req = 1'b0;
    endtask

    // Model update and per-cycle comparison, sampled away from the rising edge
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_armed = 1'b0;
            m_ack   = 1'b0;
            m_cnt   = 16'd0;
            check_output("rst_in_ready", bus.in_ready, 0);
            check_output("rst_out_valid", bus.out_valid, 0);
            check_output("rst_out_code", bus.out_code, 0);
            check_output("rst_inj_ack", inj_ack, 0);
            check_output("rst_enc_count", enc_count, 0);
        end else begin
            check_output("out_valid", bus.out_valid, exp_q.size() != 0);
            check_output("in_ready", bus.in_ready, en && (exp_q.size() < 2));
            check_output("enc_count", enc_count, m_cnt);
            check_output("inj_ack", inj_ack, m_ack);
            if (exp_q.size() != 0) begin
                check_output("out_code", bus.out_code, exp_q[0].code);
                if (bus.out_ready) begin
                    decode(bus.out_code, mon_d, mon_err);
                    check_output("loop_data", mon_d, exp_q[0].data);
                    check_output("loop_err", mon_err, exp_q[0].flipped);
                end
            end
            mon_acc = bus.in_valid && bus.in_ready;
            mon_pop = bus.out_valid && bus.out_ready && (exp_q.size() != 0);
            m_ack   = mon_acc && m_armed;
            if (mon_pop) void'(exp_q.pop_front());
            if (mon_acc) begin
                mon_e.data    = bus.in_data;
                mon_e.code    = encode(bus.in_data);
                mon_e.flipped = 1'b0;
                if (m_armed && m_pos >= 4'd1 && m_pos <= 4'd14) begin
                    mon_idx             = int'(m_pos) - 1;
                    mon_e.code[mon_idx] = ~mon_e.code[mon_idx];
                    mon_e.flipped       = 1'b1;
                end
                exp_q.push_back(mon_e);
                m_cnt = m_cnt + 16'd1;
            end
            if (inj_req) begin
                m_armed = 1'b1;
                m_pos   = inj_pos;
            end else if (mon_acc) begin
                m_armed = 1'b0;
            end
        end
    end

    // Time limit so the run always ends on its own
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] dd;
        bit         de;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Hand-computed literals that pin the model itself
        check_output("model_3ff", encode(10'h3FF), 14'h3F74);
        check_output("model_001", encode(10'h001), 14'h0007);
        check_output("model_200", encode(10'h200), 14'h208A);
        decode(14'h3F64, dd, de);
        check_output("model_dec_data", dd, 10'h3FF);
        check_output("model_dec_err", de, 1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;

        $display("[TB] basic encode");
        bus.out_ready = 1'b1;
        apply_stimulus(10'h3FF);
        check_output("basic_3ff", bus.out_code, 14'h3F74);
        apply_stimulus(10'h001);
        check_output("basic_001", bus.out_code, 14'h0007);
        apply_stimulus(10'h200);
        check_output("basic_200", bus.out_code, 14'h208A);
        idle(1);
        check_output("basic_count", enc_count, 3);

        $display("[TB] back-pressure");
        bus.out_ready = 1'b0;
        apply_stimulus(10'h055);
        apply_stimulus(10'h0AA);
        check_output("bp_full_ready", bus.in_ready, 0);
        bus.in_data = 10'h133;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_output("bp_stall_code", bus.out_code, encode(10'h055));
            check_output("bp_held_ready", bus.in_ready, 0);
        end
        check_output("bp_count", enc_count, 5);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("bp_second_code", bus.out_code, encode(10'h0AA));
        apply_stimulus(10'h133);
        idle(3);

        $display("[TB] injection");
        pulse_inj(4'd5);
        apply_stimulus(10'h3FF);
        check_output("inj_code", bus.out_code, 14'h3F64);
        check_output("inj_ack_pulse", inj_ack, 1);
        apply_stimulus(10'h3FF);
        check_output("inj_after_code", bus.out_code, 14'h3F74);
        check_output("inj_ack_once", inj_ack, 0);
        idle(1);
        pulse_inj(4'd0);
        apply_stimulus(10'h001);
        check_output("inj_pos0_code", bus.out_code, 14'h0007);
        check_output("inj_pos0_ack", inj_ack, 1);
        idle(1);
        check_output("inj_pos0_ack_end", inj_ack, 0);
        pulse_inj(4'd2);
        pulse_inj(4'd1);
        apply_stimulus(10'h001);
        check_output("inj_overwrite", bus.out_code, 14'h0006);
        idle(1);
        inj_req = 1'b1;
        inj_pos = 4'd3;
        apply_stimulus(10'h001);
        inj_req = 1'b0;
        check_output("inj_same_cycle_cur", bus.out_code, 14'h0007);
        check_output("inj_same_cycle_ack", inj_ack, 0);
        apply_stimulus(10'h001);
        check_output("inj_same_cycle_next", bus.out_code, 14'h0003);
        check_output("inj_same_cycle_ack2", inj_ack, 1);
        idle(2);

        $display("[TB] loopback");
        for (int v = 0; v < 1024; v++) apply_stimulus(10'(v));
        idle(2);
        for (int p = 1; p <= 14; p++) begin
            inj_req = 1'b1;
            inj_pos = 4'(p);
            for (int v = 0; v < 1024; v++) apply_stimulus(10'(v));
            inj_req = 1'b0;
            idle(1);
        end
        apply_stimulus(10'h000);
        idle(2);

        $display("[TB] reset mid-stream");
        bus.out_ready = 1'b0;
        apply_stimulus(10'h155);
        apply_stimulus(10'h2AA);
        idle(1);
        pulse_inj(4'd3);
        rst = 1'b1;
        #1;
        check_output("mid_rst_out_valid", bus.out_valid, 0);
        check_output("mid_rst_count", enc_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        apply_stimulus(10'h001);
        check_output("post_rst_code", bus.out_code, 14'h0007);
        check_output("post_rst_ack", inj_ack, 0);
        idle(2);

        $display("[TB] enable");
        bus.out_ready = 1'b0;
        apply_stimulus(10'h0F0);
        apply_stimulus(10'h30F);
        bus.in_data = 10'h3C3;
        en = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_output("en_low_ready", bus.in_ready, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_output("en_drained_valid", bus.out_valid, 0);
        check_output("en_drained_ready", bus.in_ready, 0);
        check_output("en_count", enc_count, 3);
        bus.in_valid = 1'b0;
        en = 1'b1;
        #1;
        check_output("en_high_ready", bus.in_ready, 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
